// File: rtl/lcd_spi_sink.sv
// lcd_spi_sink: oversampling receiver for the 4-wire LCD SPI link.
// Decodes the ST7789 command subset and emits addressed RGB565 writes.
module lcd_spi_sink #(
   parameter int SYNC_STAGES = 2,
   parameter int COORD_W     = 9,
   parameter int DEF_XE      = 239,
   parameter int DEF_YE      = 319
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               lcd_resetn,
   input  logic               lcd_clk,
   input  logic               lcd_cs,
   input  logic               lcd_rs,
   input  logic               lcd_data,
   output logic               pix_we,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [15:0]        pix_data,
   output logic               frame_done,
   output logic               cmd_strobe,
   output logic [7:0]         cmd_code,
   output logic               sleep_out,
   output logic               disp_on,
   output logic [7:0]         madctl,
   output logic [7:0]         colmod
);

   localparam logic [7:0] C_SWRESET = 8'h01;
   localparam logic [7:0] C_SLPIN   = 8'h10;
   localparam logic [7:0] C_SLPOUT  = 8'h11;
   localparam logic [7:0] C_DISPOFF = 8'h28;
   localparam logic [7:0] C_DISPON  = 8'h29;
   localparam logic [7:0] C_CASET   = 8'h2A;
   localparam logic [7:0] C_RASET   = 8'h2B;
   localparam logic [7:0] C_RAMWR   = 8'h2C;
   localparam logic [7:0] C_MADCTL  = 8'h36;
   localparam logic [7:0] C_COLMOD  = 8'h3A;

   localparam logic [COORD_W-1:0] XE0 = COORD_W'(DEF_XE);
   localparam logic [COORD_W-1:0] YE0 = COORD_W'(DEF_YE);
   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PARAM,
      S_RAMWR
   } state_t;

   logic [SYNC_STAGES-1:0] clk_sr;
   logic [SYNC_STAGES-1:0] cs_sr;
   logic [SYNC_STAGES-1:0] rs_sr;
   logic [SYNC_STAGES-1:0] dat_sr;
   logic [SYNC_STAGES-1:0] rst_sr;
   logic                   clk_q;

   logic       s_clk;
   logic       s_cs;
   logic       s_rs;
   logic       s_dat;
   logic       s_rstn;
   logic       swrst;
   logic       lreset;
   logic       rise;

   logic [2:0] bitcnt;
   logic [6:0] shreg;
   logic       byte_ok;
   logic [7:0] byte_val;
   logic       byte_dc;

   state_t       state;
   logic [7:0]   pcmd;
   logic [2:0]   pidx;
   logic [23:0]  pbuf;
   logic [15:0]  st16;
   logic [15:0]  en16;
   logic [7:0]   hi;
   logic         hi_ok;
   logic [COORD_W-1:0] xs;
   logic [COORD_W-1:0] xe;
   logic [COORD_W-1:0] ys;
   logic [COORD_W-1:0] ye;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;

   assign s_clk  = clk_sr[SYNC_STAGES-1];
   assign s_cs   = cs_sr[SYNC_STAGES-1];
   assign s_rs   = rs_sr[SYNC_STAGES-1];
   assign s_dat  = dat_sr[SYNC_STAGES-1];
   assign s_rstn = rst_sr[SYNC_STAGES-1];

   // panel reset from the controller, or the cycle after SWRESET
   assign lreset = ~s_rstn | swrst;
   assign rise   = s_clk & ~clk_q & ~s_cs;

   assign byte_ok  = rise & ~lreset & (bitcnt == 3'd7);
   assign byte_val = {shreg, s_dat};
   assign byte_dc  = s_rs;

   assign st16 = pbuf[23:8];
   assign en16 = {pbuf[7:0], byte_val};

   // bring the asynchronous link lines into the clk domain
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clk_sr <= '0;
         cs_sr  <= '1;
         rs_sr  <= '0;
         dat_sr <= '0;
         rst_sr <= '0;
         clk_q  <= 1'b0;
      end else begin
         clk_sr <= {clk_sr[SYNC_STAGES-2:0], lcd_clk};
         cs_sr  <= {cs_sr[SYNC_STAGES-2:0], lcd_cs};
         rs_sr  <= {rs_sr[SYNC_STAGES-2:0], lcd_rs};
         dat_sr <= {dat_sr[SYNC_STAGES-2:0], lcd_data};
         rst_sr <= {rst_sr[SYNC_STAGES-2:0], lcd_resetn};
         clk_q  <= s_clk;
      end
   end

   // shift MOSI on each sampled rising SCLK; CS high drops a partial byte
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bitcnt <= 3'd0;
         shreg  <= 7'd0;
      end else if (lreset || s_cs) begin
         bitcnt <= 3'd0;
      end else if (rise) begin
         shreg  <= {shreg[5:0], s_dat};
         bitcnt <= bitcnt + 3'd1;
      end
   end

   // command decoder, window registers and pixel addressing
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         pcmd       <= 8'h00;
         pidx       <= 3'd0;
         pbuf       <= 24'd0;
         hi         <= 8'h00;
         hi_ok      <= 1'b0;
         xs         <= '0;
         xe         <= XE0;
         ys         <= '0;
         ye         <= YE0;
         x          <= '0;
         y          <= '0;
         swrst      <= 1'b0;
         pix_we     <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_data   <= 16'h0000;
         frame_done <= 1'b0;
         cmd_strobe <= 1'b0;
         cmd_code   <= 8'h00;
         sleep_out  <= 1'b0;
         disp_on    <= 1'b0;
         madctl     <= 8'h00;
         colmod     <= 8'h00;
      end else if (lreset) begin
         state      <= S_IDLE;
         pcmd       <= 8'h00;
         pidx       <= 3'd0;
         pbuf       <= 24'd0;
         hi         <= 8'h00;
         hi_ok      <= 1'b0;
         xs         <= '0;
         xe         <= XE0;
         ys         <= '0;
         ye         <= YE0;
         x          <= '0;
         y          <= '0;
         swrst      <= 1'b0;
         pix_we     <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_data   <= 16'h0000;
         frame_done <= 1'b0;
         cmd_strobe <= 1'b0;
         cmd_code   <= 8'h00;
         sleep_out  <= 1'b0;
         disp_on    <= 1'b0;
         madctl     <= 8'h00;
         colmod     <= 8'h00;
      end else begin
         pix_we     <= 1'b0;
         frame_done <= 1'b0;
         cmd_strobe <= 1'b0;
         swrst      <= 1'b0;
         if (byte_ok && !byte_dc) begin
            cmd_strobe <= 1'b1;
            cmd_code   <= byte_val;
            pcmd       <= byte_val;
            pidx       <= 3'd0;
            hi_ok      <= 1'b0;
            state      <= S_IDLE;
            case (byte_val)
               C_CASET, C_RASET, C_MADCTL, C_COLMOD:
                  state <= S_PARAM;
               C_RAMWR: begin
                  state <= S_RAMWR;
                  x     <= xs;
                  y     <= ys;
               end
               C_SLPOUT:  sleep_out <= 1'b1;
               C_SLPIN:   sleep_out <= 1'b0;
               C_DISPON:  disp_on   <= 1'b1;
               C_DISPOFF: disp_on   <= 1'b0;
               C_SWRESET: swrst     <= 1'b1;
               default: ;
            endcase
         end else if (byte_ok) begin
            case (state)
               S_PARAM: begin
                  pbuf <= {pbuf[15:0], byte_val};
                  if (pidx != 3'd4)
                     pidx <= pidx + 3'd1;
                  if (pidx == 3'd0 && pcmd == C_MADCTL)
                     madctl <= byte_val;
                  if (pidx == 3'd0 && pcmd == C_COLMOD)
                     colmod <= byte_val;
                  if (pidx == 3'd3 && pcmd == C_CASET) begin
                     xs <= st16[COORD_W-1:0];
                     xe <= en16[COORD_W-1:0];
                  end
                  if (pidx == 3'd3 && pcmd == C_RASET) begin
                     ys <= st16[COORD_W-1:0];
                     ye <= en16[COORD_W-1:0];
                  end
               end
               S_RAMWR: begin
                  if (!hi_ok) begin
                     hi    <= byte_val;
                     hi_ok <= 1'b1;
                  end else begin
                     hi_ok      <= 1'b0;
                     pix_we     <= 1'b1;
                     pix_data   <= {hi, byte_val};
                     pix_x      <= x;
                     pix_y      <= y;
                     frame_done <= (x == xe) && (y == ye);
                     if (x == xe) begin
                        x <= xs;
                        y <= (y == ye) ? ys : y + ONE;
                     end else begin
                        x <= x + ONE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_spi_sink.sv
// tb_lcd_spi_sink: drives the SPI link and scoreboards pixel writes
// and command strobes against expectations queued with the stimulus.
module tb_lcd_spi_sink;

   logic       clk;
   logic       resetn;
   logic       lcd_resetn;
   logic       lcd_clk;
   logic       lcd_cs;
   logic       lcd_rs;
   logic       lcd_data;
   logic       pix_we;
   logic [8:0] pix_x;
   logic [8:0] pix_y;
   logic [15:0] pix_data;
   logic       frame_done;
   logic       cmd_strobe;
   logic [7:0] cmd_code;
   logic       sleep_out;
   logic       disp_on;
   logic [7:0] madctl;
   logic [7:0] colmod;

   int total = 0;
   int bad   = 0;

   logic [34:0] pq[$];
   logic [7:0]  cq[$];

   lcd_spi_sink dut (
      .clk        (clk),
      .resetn     (resetn),
      .lcd_resetn (lcd_resetn),
      .lcd_clk    (lcd_clk),
      .lcd_cs     (lcd_cs),
      .lcd_rs     (lcd_rs),
      .lcd_data   (lcd_data),
      .pix_we     (pix_we),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_data   (pix_data),
      .frame_done (frame_done),
      .cmd_strobe (cmd_strobe),
      .cmd_code   (cmd_code),
      .sleep_out  (sleep_out),
      .disp_on    (disp_on),
      .madctl     (madctl),
      .colmod     (colmod)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bit(input logic dc, input logic b);
      lcd_rs   = dc;
      lcd_data = b;
      tick(4);
      lcd_clk = 1'b1;
      tick(4);
      lcd_clk = 1'b0;
   endtask

   task automatic send_byte(input logic dc, input logic [7:0] b);
      lcd_cs = 1'b0;
      for (int i = 7; i >= 0; i--)
         spi_bit(dc, b[i]);
      tick(2);
   endtask

   task automatic cmd(input logic [7:0] c);
      cq.push_back(c);
      send_byte(1'b0, c);
   endtask

   task automatic dat(input logic [7:0] b);
      send_byte(1'b1, b);
   endtask

   task automatic pix(input logic [8:0] px, input logic [8:0] py,
                      input logic [15:0] d, input logic fd);
      pq.push_back({fd, px, py, d});
      dat(d[15:8]);
      dat(d[7:0]);
   endtask

   // scoreboard: compare every strobe with the next queued expectation
   always @(negedge clk) begin
      if (resetn) begin
         if (pix_we) begin
            if (pq.size() == 0)
               chk("pix_unexp", {frame_done, pix_x, pix_y, pix_data}, 0);
            else
               chk("pix", {frame_done, pix_x, pix_y, pix_data},
                   pq.pop_front());
         end
         if (frame_done && !pix_we)
            chk("fd_alone", 1, 0);
         if (cmd_strobe) begin
            if (cq.size() == 0)
               chk("cmd_unexp", cmd_code, 0);
            else
               chk("cmd", cmd_code, cq.pop_front());
         end
      end
   end

   initial begin
      resetn     = 1'b0;
      lcd_resetn = 1'b1;
      lcd_clk    = 1'b0;
      lcd_cs     = 1'b1;
      lcd_rs     = 1'b0;
      lcd_data   = 1'b0;
      tick(3);
      chk("rst_pix_we", pix_we, 0);
      resetn = 1'b1;
      tick(10);
      chk("idle_outs", {pix_we, frame_done, cmd_strobe, sleep_out,
                        disp_on, pix_x, pix_y, pix_data}, 0);
      chk("idle_code", {cmd_code, madctl, colmod}, 0);

      cmd(8'h11);
      cmd(8'h29);
      tick(4);
      chk("sleep_out", sleep_out, 1);
      chk("disp_on", disp_on, 1);

      cmd(8'h36); dat(8'h60); dat(8'h77);
      cmd(8'h3A); dat(8'h55);
      tick(4);
      chk("madctl", madctl, 8'h60);
      chk("colmod", colmod, 8'h55);

      cmd(8'h2A); dat(8'h00); dat(8'h28); dat(8'h01); dat(8'h17);
      cmd(8'h2B); dat(8'h00); dat(8'h35); dat(8'h00); dat(8'hBB);
      cmd(8'h2C);
      pix(9'd40, 9'd53, 16'hF800, 1'b0);
      pix(9'd41, 9'd53, 16'h07E0, 1'b0);

      cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h00);
      cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
      cmd(8'h2C);
      pix(9'd0, 9'd0, 16'h1111, 1'b0);
      pix(9'd0, 9'd1, 16'h2222, 1'b1);
      pix(9'd0, 9'd0, 16'h3333, 1'b0);

      cmd(8'h01);
      tick(4);
      chk("swrst_sleep", sleep_out, 0);
      chk("swrst_regs", {disp_on, madctl, colmod, cmd_code}, 0);

      cmd(8'h2A); dat(8'h00); dat(8'h10);
      cmd(8'h2C);
      pix(9'd0, 9'd0, 16'h1234, 1'b0);
      pix(9'd1, 9'd0, 16'h5678, 1'b0);

      cmd(8'h2C);
      dat(8'hAB);
      lcd_cs = 1'b1;
      tick(5);
      spi_bit(1'b1, 1'b1);
      spi_bit(1'b1, 1'b0);
      lcd_cs = 1'b0;
      spi_bit(1'b1, 1'b1);
      spi_bit(1'b1, 1'b1);
      spi_bit(1'b1, 1'b1);
      lcd_cs = 1'b1;
      tick(5);
      pq.push_back({1'b0, 9'd0, 9'd0, 16'hABCD});
      dat(8'hCD);
      dat(8'hEF);

      cmd(8'h11);
      cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
      cmd(8'h2C);
      pix(9'd5, 9'd0, 16'h0F0F, 1'b0);
      dat(8'h12);
      lcd_resetn = 1'b0;
      tick(3);
      lcd_resetn = 1'b1;
      tick(6);
      chk("lrst_sleep", sleep_out, 0);
      chk("lrst_code", cmd_code, 0);
      dat(8'h34);
      dat(8'h56);
      cmd(8'h2C);
      pix(9'd0, 9'd0, 16'h7788, 1'b0);

      tick(20);
      chk("pix_left", pq.size(), 0);
      chk("cmd_left", cq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lcd_spi_sink.md
Name: lcd_spi_sink

Overview:
- Display-side receiver for the 4-wire write-only SPI link (SCLK, CS, D/C, MOSI) driven by our LCD controller.
- Oversamples the link in its own faster clock domain, assembles bytes and decodes the ST7789 command subset we emit (SLPOUT/SLPIN, DISPON/DISPOFF, MADCTL, COLMOD, CASET, RASET, RAMWR, SWRESET).
- Produces addressed RGB565 pixel writes for a framebuffer/checker.
- Used as an in-FPGA loopback target and as the bench's display model.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on lcd_clk/lcd_cs/lcd_rs/lcd_data/lcd_resetn (min 2).
- COORD_W, 9, width of pix_x/pix_y and window registers.
- DEF_XE, 239, column window end after any reset.
- DEF_YE, 319, row window end after any reset.

Ports:
- clk  in  1  system clock; each lcd_clk high and low phase must last >=2 clk periods plus SYNC_STAGES skew tolerance.
- resetn  in  1  asynchronous active-low reset.
- lcd_resetn  in  1  panel reset from controller, async to clk; low = logical reset.
- lcd_clk  in  1  SPI clock; data sampled on rising edge.
- lcd_cs  in  1  chip select, active low.
- lcd_rs  in  1  D/C: 0 = command, 1 = data.
- lcd_data  in  1  MOSI, MSB first.
- pix_we  out  1  one-cycle pixel write strobe.
- pix_x  out  COORD_W  column of the pixel write.
- pix_y  out  COORD_W  row of the pixel write.
- pix_data  out  16  RGB565 pixel, first byte = [15:8].
- frame_done  out  1  one-cycle pulse with the pix_we at (xe,ye).
- cmd_strobe  out  1  one-cycle pulse per received command byte.
- cmd_code  out  8  last command byte.
- sleep_out  out  1  1 after SLPOUT (0x11), 0 after SLPIN (0x10).
- disp_on  out  1  1 after DISPON (0x29), 0 after DISPOFF (0x28).
- madctl  out  8  last MADCTL (0x36) parameter.
- colmod  out  8  last COLMOD (0x3A) parameter.

Behaviour:
- Interface: one clock, clk; reset resetn is asynchronous and active-low.
- Reset (resetn low, synchronized lcd_resetn low, or SWRESET 0x01 completion):
  - All outputs 0, except colmod=8'h00 and madctl=8'h00.
  - Window xs=0, xe=DEF_XE, ys=0, ye=DEF_YE.
  - Decoder IDLE, bit counter 0, pending half-pixel discarded.
  - SWRESET does pulse cmd_strobe first; reset takes effect the cycle after.
- Byte assembly:
  - Synchronized lcd_clk 0->1 while synchronized lcd_cs==0: shift in lcd_data, bitcnt++.
  - On 8th bit the byte completes; D/C is taken from lcd_rs sampled with that 8th bit.
  - lcd_cs high clears bitcnt (partial byte discarded) but does not change decoder state; commands and pixels span CS toggles.
- Latency: outputs for a completed byte update/pulse exactly 1 clk after the completing edge is detected.
- Decoder states: IDLE, PARAM, RAMWR.
  - Command byte, any state: cmd_strobe, cmd_code=byte.
    - 0x2A/0x2B/0x36/0x3A -> PARAM, param index 0.
    - 0x2C -> RAMWR, x=xs, y=ys, half-pixel flag cleared.
    - 0x11/0x10/0x29/0x28 set/clear flags -> IDLE.
    - Others -> IDLE; their data ignored.
    - Any command aborts an incomplete CASET/RASET (window unchanged) and drops a pending half-pixel.
  - PARAM:
    - CASET/RASET take 4 bytes, big-endian start then end, each truncated to COORD_W.
    - Window registers update only on the 4th byte; bytes 5+ ignored.
    - MADCTL/COLMOD take byte 0; further bytes ignored.
  - RAMWR:
    - Even data byte latched as high byte.
    - Odd byte: pix_we=1, pix_data={hi,byte}, pix_x=x, pix_y=y.
    - Address advance: if x==xe then x=xs, and y = (y==ye) ? ys : y+1; else x = x+1 mod 2^COORD_W.
    - frame_done with the write where x==xe && y==ye; addressing wraps to (xs,ys) and continues.
    - xs>xe or ys>ye: no clamping; the equality compare plus modular increment defines the sequence.
  - Data byte in IDLE: ignored.
- lcd_resetn asserted mid-byte or mid-frame: immediate logical reset. Activity resumes only on bytes starting after lcd_resetn is released.

Test Plan:
- resetn pulse, then idle lines -> all outputs 0, no strobes; send 0x11, 0x29 -> two cmd_strobe pulses (cmd_code 0x11, then 0x29), sleep_out=1, disp_on=1.
- CASET 00 28 01 17, RASET 00 35 00 BB, RAMWR, pixels F800 07E0 -> writes (40,53)=F800, (41,53)=07E0.
- Window xs=xe=0, ys=0, ye=1, RAMWR, 3 pixels -> (0,0), (0,1) with frame_done, (0,0).
- CASET 00 10 then command 0x2C -> window unchanged (0..239); first write at (0,0).
- RAMWR, data AB, CS high for 5 clk, CS low, 3 bits, CS high, then CD EF -> pixel ABCD at (0,0); bits shifted under CS high are not counted.
- Mid-frame lcd_resetn low 3 clk -> window defaults restored, sleep_out=0, no pix_we until a new RAMWR.
